data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Responder end of the pipeline's data-memory request interface: accepts single-beat `req`/`addr`/`write`/`width`/`extend` requests from the memory stage, performs byte/halfword/word accesses on an internal word-organised synchronous RAM, and returns `ack` plus read data. Sits between the memory stage and on-chip data storage. Configurable wait states model slower memories without changing the initiator.

## Interface

Parameters:

- `DEPTH_WORDS`, 4096: RAM size in 32-bit words (power of two).
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be aligned to `DEPTH_WORDS*4`.
- `WAIT_CYCLES`, 0: extra cycles `req` must be held before `ack` (0–15).

Ports:

- `clk` in 1: clock; all state updates on the rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `req` in 1: request valid; held by the initiator until `ack`.
- `addr` in 32: byte address.
- `write` in 1: 1 = store, 0 = load.
- `wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `extend` in 1: loads only. 1 = sign-extend, 0 = zero-extend.
- `width` in 2: 0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- `ack` out 1: request completes in this cycle.
- `rdata` out 32: load result, valid from the cycle after a load's `ack` until the next load's `ack` + 1.
- `fault` out 1: registered; pulses for one cycle after an `ack` for a faulting request.

## Operation

- Decode: `off = addr - BASE_ADDR`. `index = off[.. :2]`. `lane = addr[1:0]`.
- Fault conditions:
  - `width==3`.
  - Halfword with `lane[0]==1`.
  - Word with `lane!=0`.
  - `off >= DEPTH_WORDS*4`.
- Faulting request:
  - Still acked with normal timing, so the pipeline never deadlocks.
  - Store is suppressed, a load returns `rdata = 0`, and `fault` is 1 in the following cycle.
- Stores are read-modify-free, using byte enables:
  - Byte: lane `lane` ← `wdata[7:0]`.
  - Half: lanes `lane`, `lane+1` ← `wdata[15:0]`.
  - Word: all lanes.
- Loads:
  - Select bytes at `lane` and right-align them.
  - If `extend`, fill the upper bits with the MSB of the selected field; otherwise fill with zeros.
  - Word loads ignore `extend`.
- FSM states:
  - IDLE → (`req` && `WAIT_CYCLES>0`) → BUSY (load counter with `WAIT_CYCLES`).
  - BUSY decrements each cycle. Count reaching 0 with `req` high → `ack` and return to IDLE.
  - BUSY with `req` low → IDLE, counter cleared, no side effect (protocol violation tolerated).
- `ack`:
  - `WAIT_CYCLES==0`: `ack = req & reset_n`, combinational, in the same cycle.
  - Otherwise `ack` is asserted in the (`WAIT_CYCLES`+1)-th consecutive cycle of `req`.
- RAM contents are not reset and are uninitialised.

## Timing

- Reset values (asserted asynchronously): `ack`=0, `rdata`=0, `fault`=0, state=IDLE, counter=0.
- Reset mid-BUSY aborts the request: no write, no `ack`; the initiator re-requests after reset.
- Store commits at the rising edge that ends the `ack` cycle.
- Load data is sampled at that same edge. `rdata` is valid in the cycle after `ack` and held until the edge ending the next load's `ack` cycle.
- Stores and faulting stores leave `rdata` unchanged.
- Back-to-back requests with `WAIT_CYCLES==0`: one per cycle, with no bubble.
- Store then load to the same word in consecutive cycles: the load returns the new data (write-first at the RAM port).
- Throughput is 1 request per `WAIT_CYCLES+1` cycles.
- `fault` is high exactly in the cycle after a faulting `ack`, and low otherwise.

## Test plan

- Reset while `req`=1, `WAIT_CYCLES=3`, after 2 cycles → `ack` never asserts, outputs 0. After release and re-request, `ack` arrives on the 4th cycle.
- Store word 0x8899AABB @0x0, then loads:
  - Byte @0x1, sign-extend → 0xFFFFFFAA.
  - Byte @0x1, zero-extend → 0x000000AA.
  - Half @0x2, sign-extend → 0xFFFF8899.
  - Word @0x0 → 0x8899AABB.
  - Each load's value appears the cycle after its `ack`.
- Store byte 0x11 @0x3 over 0x8899AABB, then load word @0x0 → 0x1199AABB. Back-to-back with `WAIT_CYCLES=0`, one `ack` per cycle.
- Misaligned half @0x1, word @0x2, and `width=3` → each acked, `fault`=1 next cycle. Memory unchanged, load `rdata`=0.
- Out-of-range word @ `BASE_ADDR + DEPTH_WORDS*4` → `fault`; a store there does not alias into word 0.
- `WAIT_CYCLES=2`:
  - `req` held → `ack` on the 3rd cycle.
  - `req` dropped in the 2nd cycle → no `ack`, no write, FSM back to IDLE.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: single-beat byte/half/word accesses on a word-wide
// RAM, with optional wait states and a registered fault pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no request in flight (ack is immediate when WAIT_CYCLES==0)
// ST_BUSY | counting down wait states while req is held
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        write_i,
  input  logic [31:0] wdata_i,
  input  logic        extend_i,
  input  logic [1:0]  width_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        fault_o
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]   off;
  logic [AW-1:0] index;
  logic [1:0]    lane;
  logic          in_range;
  logic          req_fault;
  logic [3:0]    be;
  logic [31:0]   wdata_sh;
  logic [31:0]   rd_word;
  logic [31:0]   rd_sh;

  // Address decode; an address below BASE_ADDR wraps to a huge offset and faults.
  assign off      = addr_i - BASE_ADDR;
  assign index    = off[AW+1:2];
  assign lane     = addr_i[1:0];
  assign in_range = (off >> (AW + 2)) == 32'd0;

  // Ack is combinational: immediate with no wait states, else on the last count.
  assign ack_o = req_i & reset_n_i &
                 ((WAIT_CYCLES == 0) | ((state_q == ST_BUSY) & (cnt_q == 4'd1)));

  // Fault classification and byte-enable generation for the current request.
  always_comb begin
    req_fault = ~in_range;
    be        = 4'b1111;
    case (width_i)
      2'd0: be = 4'b0001 << lane;
      2'd1: begin
        be = 4'b0011 << lane;
        if (lane[0]) req_fault = 1'b1;
      end
      2'd2: if (lane != 2'd0) req_fault = 1'b1;
      default: req_fault = 1'b1;
    endcase
  end

  assign wdata_sh = wdata_i << {lane, 3'b000};

  // Load path: select the addressed field, right-align and extend.
  always_comb begin
    rd_word = mem[index];
    rd_sh   = rd_word >> {lane, 3'b000};
    case (width_i)
      2'd0:    rdata_d = {{24{extend_i & rd_sh[7]}}, rd_sh[7:0]};
      2'd1:    rdata_d = {{16{extend_i & rd_sh[15]}}, rd_sh[15:0]};
      default: rdata_d = rd_word;
    endcase
    if (req_fault) rdata_d = '0;
    fault_d = ack_o & req_fault;
  end

  // RAM write port: byte-enabled store on the edge ending the ack cycle.
  always_ff @(posedge clk_i) begin
    if (ack_o && write_i && !req_fault) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[index][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  // Wait-state FSM; a dropped req abandons the request without side effects.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_i && (WAIT_LD != 4'd0)) begin
            state_q <= ST_BUSY;
            cnt_q   <= WAIT_LD;
          end
        end
        default: begin
          if (!req_i || (cnt_q == 4'd1)) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
      endcase
    end
  end

  // Registered outputs: load data held until the next load, one-cycle fault pulse.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
      if (ack_o && !write_i) rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;
  assign fault_o = fault_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances with 0, 2 and 3 wait
// states; expected results are queued at issue and checked the cycle after ack.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req   [3];
  logic [31:0] addr  [3];
  logic        wr    [3];
  logic [31:0] wdata [3];
  logic        ext   [3];
  logic [1:0]  width [3];
  logic        ack   [3];
  logic [31:0] rdata [3];
  logic        fault [3];

  int          wc [3] = '{0, 2, 3};
  logic [31:0] last_rd [3];

  typedef struct {
    int          k;
    logic [31:0] rd;
    logic        f;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0)) u0 (
    .clk_i(clk), .reset_n_i(reset_n), .req_i(req[0]), .addr_i(addr[0]), .write_i(wr[0]),
    .wdata_i(wdata[0]), .extend_i(ext[0]), .width_i(width[0]),
    .ack_o(ack[0]), .rdata_o(rdata[0]), .fault_o(fault[0]));

  data_mem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h1000_0000), .WAIT_CYCLES(2)) u1 (
    .clk_i(clk), .reset_n_i(reset_n), .req_i(req[1]), .addr_i(addr[1]), .write_i(wr[1]),
    .wdata_i(wdata[1]), .extend_i(ext[1]), .width_i(width[1]),
    .ack_o(ack[1]), .rdata_o(rdata[1]), .fault_o(fault[1]));

  data_mem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(3)) u2 (
    .clk_i(clk), .reset_n_i(reset_n), .req_i(req[2]), .addr_i(addr[2]), .write_i(wr[2]),
    .wdata_i(wdata[2]), .extend_i(ext[2]), .width_i(width[2]),
    .ack_o(ack[2]), .rdata_o(rdata[2]), .fault_o(fault[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("rdata[u%0d]", e.k), rdata[e.k], e.rd);
      chk($sformatf("fault[u%0d]", e.k), {31'd0, fault[e.k]}, {31'd0, e.f});
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the ack edge,
  // with req still high so a following issue runs back-to-back.
  task automatic issue(input int k, input logic w, input logic [1:0] wid, input logic ex,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_f);
    int   n;
    exp_t e;
    req[k] = 1'b1; wr[k] = w; width[k] = wid; ext[k] = ex; addr[k] = a; wdata[k] = wd;
    n = 1;
    #1;
    while (ack[k] !== 1'b1 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk($sformatf("ack_latency[u%0d]@%h", k, a), (ack[k] === 1'b1) ? n : 0, wc[k] + 1);
    e.k = k;
    e.f = exp_f;
    if (w) e.rd = last_rd[k];
    else begin
      e.rd = exp_rd;
      last_rd[k] = exp_rd;
    end
    sb.push_back(e);
    @(negedge clk);
    check_pop();
  endtask

  task automatic idle(input int k);
    req[k] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; addr[i] = '0; wr[i] = 1'b0; wdata[i] = '0;
      ext[i] = 1'b0; width[i] = 2'd0; last_rd[i] = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_ack[u%0d]", i), {31'd0, ack[i]}, 32'd0);
      chk($sformatf("reset_rdata[u%0d]", i), rdata[i], 32'd0);
      chk($sformatf("reset_fault[u%0d]", i), {31'd0, fault[i]}, 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // u2 (3 wait states): reset mid-request aborts the store
    issue(2, 1'b1, 2'd2, 1'b0, 32'h0, 32'h1234_5678, 32'h0, 1'b0);
    issue(2, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h1234_5678, 1'b0);
    idle(2);
    @(negedge clk);
    req[2] = 1'b1; wr[2] = 1'b1; width[2] = 2'd2; addr[2] = 32'h0; wdata[2] = 32'hDEAD_BEEF;
    #1 chk("abort_ack_c1", {31'd0, ack[2]}, 32'd0);
    @(negedge clk);
    #1 chk("abort_ack_c2", {31'd0, ack[2]}, 32'd0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_rdata", rdata[2], 32'd0);
    chk("abort_fault", {31'd0, fault[2]}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 chk("abort_ack_in_reset", {31'd0, ack[2]}, 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    req[2] = 1'b0;
    for (int i = 0; i < 3; i++) last_rd[i] = '0;
    @(negedge clk);
    issue(2, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h1234_5678, 1'b0);
    issue(2, 1'b1, 2'd2, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b0);
    issue(2, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    idle(2);

    // u0 (no wait states): back-to-back sub-word accesses
    issue(0, 1'b1, 2'd2, 1'b0, 32'h0, 32'h8899_AABB, 32'h0, 1'b0);
    issue(0, 1'b0, 2'd0, 1'b1, 32'h1, 32'h0, 32'hFFFF_FFAA, 1'b0);
    issue(0, 1'b0, 2'd0, 1'b0, 32'h1, 32'h0, 32'h0000_00AA, 1'b0);
    issue(0, 1'b0, 2'd1, 1'b1, 32'h2, 32'h0, 32'hFFFF_8899, 1'b0);
    issue(0, 1'b0, 2'd2, 1'b1, 32'h0, 32'h0, 32'h8899_AABB, 1'b0);
    issue(0, 1'b1, 2'd0, 1'b0, 32'h3, 32'hFFFF_FF11, 32'h0, 1'b0);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h1199_AABB, 1'b0);
    issue(0, 1'b0, 2'd1, 1'b0, 32'h2, 32'h0, 32'h0000_1199, 1'b0);
    issue(0, 1'b0, 2'd1, 1'b1, 32'h0, 32'h0, 32'hFFFF_AABB, 1'b0);
    issue(0, 1'b1, 2'd1, 1'b0, 32'h2, 32'hABCD_7F55, 32'h0, 1'b0);
    issue(0, 1'b0, 2'd0, 1'b1, 32'h3, 32'h0, 32'h0000_007F, 1'b0);
    issue(0, 1'b0, 2'd0, 1'b1, 32'h2, 32'h0, 32'h0000_0055, 1'b0);
    // faulting requests: misaligned, illegal width, out of range
    issue(0, 1'b0, 2'd1, 1'b1, 32'h1, 32'h0, 32'h0, 1'b1);
    issue(0, 1'b1, 2'd2, 1'b0, 32'h2, 32'h0000_0000, 32'h0, 1'b1);
    issue(0, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    issue(0, 1'b1, 2'd3, 1'b0, 32'h0, 32'h0000_0000, 32'h0, 1'b1);
    issue(0, 1'b1, 2'd2, 1'b0, 32'h400, 32'hDEAD_BEEF, 32'h0, 1'b1);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h7F55_AABB, 1'b0);
    idle(0);
    @(negedge clk);
    #1 chk("fault_idle[u0]", {31'd0, fault[0]}, 32'd0);

    // u1 (2 wait states, non-zero base): held req and dropped req
    issue(1, 1'b1, 2'd2, 1'b0, 32'h1000_0008, 32'h1111_1111, 32'h0, 1'b0);
    idle(1);
    @(negedge clk);
    req[1] = 1'b1; wr[1] = 1'b1; width[1] = 2'd2; addr[1] = 32'h1000_0008; wdata[1] = 32'h2222_2222;
    #1 chk("drop_ack_c1", {31'd0, ack[1]}, 32'd0);
    @(negedge clk);
    req[1] = 1'b0;
    #1 chk("drop_ack_c2", {31'd0, ack[1]}, 32'd0);
    @(negedge clk);
    issue(1, 1'b0, 2'd2, 1'b0, 32'h1000_0008, 32'h0, 32'h1111_1111, 1'b0);
    issue(1, 1'b0, 2'd2, 1'b0, 32'h0FFF_FFFC, 32'h0, 32'h0, 1'b1);
    issue(1, 1'b0, 2'd2, 1'b0, 32'h1000_0100, 32'h0, 32'h0, 1'b1);
    issue(1, 1'b0, 2'd0, 1'b1, 32'h1000_000B, 32'h0, 32'h0000_0011, 1'b0);
    idle(1);
    repeat (2) @(negedge clk);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
